cart_load_ctrl: RTL and testbench
=================================

# cart_load_ctrl

Sequences cartridge image download from the HPS ioctl channel into the Vectrex core. It qualifies and registers cartridge writes, derives the cartridge address mask from the image size, and holds the core in reset while loading. When skip-logo is selected, it issues a delayed second reset after the download completes. It sits between `hps_io` and `vectrex` in the `emu` top level and replaces the ad-hoc mask and reset logic there.

## Interface
Parameters:
- `SKIP_DELAY`, 5000000: total cycles from download end to end of second reset.
- `PULSE_LEN`, 1000: cycles `load_reset` is held high at the end of `SKIP_DELAY`. Must be ≥1 and < `SKIP_DELAY`.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous reset, active-high.
- `ioctl_download` in 1: download in progress.
- `ioctl_wr` in 1: one-cycle write strobe.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `skip_logo` in 1: status[11], sampled at download end.
- `cart_wr` out 1: registered qualified write strobe.
- `cart_addr` out 15: registered write address.
- `cart_data` out 8: registered write data.
- `cart_mask` out 15: cartridge address mask.
- `oversize` out 1: sticky; a write with `ioctl_addr[24:15]`≠0 occurred during this download.
- `load_reset` out 1: core reset request.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: default state.
  - LOAD: a download is in progress.
  - SETTLE: waiting before the second reset.
  - PULSE: second reset is asserted.
- `load_reset` = (state==LOAD) | (state==PULSE).
- Transitions:
  - IDLE→LOAD: on rising edge of `ioctl_download`.
  - LOAD→SETTLE: on falling edge of `ioctl_download` when `skip_logo`=1. The timer is loaded with `SKIP_DELAY-PULSE_LEN-1`.
  - LOAD→IDLE: on falling edge of `ioctl_download` when `skip_logo`=0.
  - SETTLE→PULSE: when the timer reaches 0. The timer is reloaded with `PULSE_LEN-1`.
  - PULSE→IDLE: when the timer reaches 0.
- Edge detection uses a registered copy of `ioctl_download`, which resets to 0.
- A rising edge of `ioctl_download` in SETTLE or PULSE aborts the timer and enters LOAD.
- On entry to LOAD: `cart_mask`←0 and `oversize`←0.
- Qualified write: `ioctl_wr & ioctl_download & (ioctl_addr[24:15]==0)`.
  - Registers `cart_addr`←`ioctl_addr[14:0]` and `cart_data`←`ioctl_dout`.
  - Pulses `cart_wr` for 1 cycle.
  - If `ioctl_addr[14:0] & ~cart_mask` ≠ 0, then `cart_mask`←`{cart_mask[13:0],1'b1}`. The mask grows by at most one bit per write.
- Unqualified write with the upper address bits non-zero: `oversize`←1, no `cart_wr`, mask unchanged.
- `ioctl_wr` while `ioctl_download`=0: ignored.
- The timer is 23 bits wide and counts down by 1. It is only active in SETTLE and PULSE.

## Timing
- Reset values:
  - state IDLE, timer 0.
  - `cart_wr` 0, `cart_addr` 0, `cart_data` 0, `cart_mask` 0.
  - `oversize` 0, `load_reset` 0, `busy` 0.
- `load_reset` and `busy` are registered. They rise 1 cycle after the `ioctl_download` rising edge is sampled.
- `cart_wr`, `cart_addr` and `cart_data` appear 1 cycle after the `ioctl_wr` cycle.
- `cart_mask` updates in the same cycle that `cart_wr` asserts.
- Download end with skip: `load_reset` falls 1 cycle after the falling edge. It then stays low for `SKIP_DELAY-PULSE_LEN` cycles and high for `PULSE_LEN` cycles. The whole sequence, from the falling edge to `load_reset` low again, spans `SKIP_DELAY`+1 cycles.
- Simultaneous events:
  - Download rise and write in the same cycle: the write is qualified, and the mask clear takes priority over the mask grow.
  - Download fall and write in the same cycle: the write is ignored.
- `reset` mid-sequence forces all outputs to their reset values on the next edge. An in-progress download is not resumed; the next rising edge restarts it.

## Structure
- Package `vectrex_pkg` holds:
  - the state enum `cart_load_state_t`;
  - `CART_ADDR_W`=15;
  - the default `SKIP_DELAY` and `PULSE_LEN` values.
- One sub-module, `cart_skip_timer`: a loadable down-counter with a `zero` flag, used for both SETTLE and PULSE.
- The `emu` top level ORs `load_reset` into the core reset term.

## Test plan
- Download of 8192 bytes at addr 0..8191 with `skip_logo`=0:
  - 8192 `cart_wr` pulses.
  - `cart_mask`=0x1FFF.
  - `load_reset` high throughout, low 1 cycle after the download falls.
  - `busy`=0 afterwards.
- Same 8192-byte download with `skip_logo`=1, `SKIP_DELAY`=100, `PULSE_LEN`=10:
  - `load_reset` low for 90 cycles, high for 10, then IDLE.
- Write to addr 0x8000 during download:
  - `oversize`=1, no `cart_wr`, mask unchanged.
  - `oversize` clears on the next download start.
- New download rising during SETTLE:
  - immediate LOAD, `cart_mask`=0.
  - No PULSE occurs from the prior sequence.
- `reset` asserted in PULSE and in LOAD:
  - All outputs return to their reset values on the next cycle.
- Download rise coincident with a write to addr 3 while the mask is stale at 0x7FFF:
  - Mask clears, and the write produces `cart_wr` with `cart_addr`=3.

Source files
------------

// File: rtl/vectrex_pkg.sv
// Shared types and constants for the Vectrex cartridge loader.
// Holds the loader state encoding, bus widths and default timing values.
package vectrex_pkg;

    localparam int CART_ADDR_W    = 15;
    localparam int IOCTL_ADDR_W   = 25;
    localparam int TIMER_W        = 23;
    localparam int SKIP_DELAY_DEF = 5000000;
    localparam int PULSE_LEN_DEF  = 1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_PULSE  = 2'd3
    } cart_load_state_t;

    // Widen a contiguous low-order mask by one bit.
    function automatic logic [CART_ADDR_W-1:0] mask_grow(input logic [CART_ADDR_W-1:0] m);
        return {m[CART_ADDR_W-2:0], 1'b1};
    endfunction

endpackage

// File: rtl/cart_load_ctrl_if.sv
// HPS ioctl download channel plus the cartridge write/control outputs of the loader.
// master = ioctl/HPS side driving downloads, slave = the loader.
interface cart_load_ctrl_if;
    import vectrex_pkg::*;

    logic                    ioctl_download;
    logic                    ioctl_wr;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic [7:0]              ioctl_dout;
    logic                    skip_logo;
    logic                    cart_wr;
    logic [CART_ADDR_W-1:0]  cart_addr;
    logic [7:0]              cart_data;
    logic [CART_ADDR_W-1:0]  cart_mask;
    logic                    oversize;
    logic                    load_reset;
    logic                    busy;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, skip_logo,
        input  cart_wr, cart_addr, cart_data, cart_mask, oversize, load_reset, busy
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, skip_logo,
        output cart_wr, cart_addr, cart_data, cart_mask, oversize, load_reset, busy
    );

endinterface

// File: rtl/cart_skip_timer.sv
// Loadable down-counter with zero flag, shared by the settle and pulse phases.
// Latency: load visible next cycle; no backpressure, counting stops at zero.
module cart_skip_timer
    import vectrex_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cart_load_ctrl.sv
// Qualifies ioctl cartridge writes, tracks the address mask and sequences core reset.
// Latency: all outputs registered, 1 cycle after the input cycle; no backpressure (ioctl cannot stall).
module cart_load_ctrl
    import vectrex_pkg::*;
#(
    parameter int SKIP_DELAY = SKIP_DELAY_DEF,
    parameter int PULSE_LEN  = PULSE_LEN_DEF
) (
    input  logic             clk_sys,
    input  logic             reset,
    cart_load_ctrl_if.slave  bus
);

    localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SKIP_DELAY - PULSE_LEN - 1);
    localparam logic [TIMER_W-1:0] PULSE_LD  = TIMER_W'(PULSE_LEN - 1);

    cart_load_state_t   state;
    logic               dl_q;
    logic               dl_rise;
    logic               dl_fall;
    logic               addr_hi_nz;
    logic               wr_ok;
    logic               wr_over;
    logic               grow;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_en;
    logic               tmr_zero;

    assign dl_rise    = bus.ioctl_download & ~dl_q;
    assign dl_fall    = ~bus.ioctl_download & dl_q;
    assign addr_hi_nz = |bus.ioctl_addr[IOCTL_ADDR_W-1:CART_ADDR_W];
    assign wr_ok      = bus.ioctl_wr & bus.ioctl_download & ~addr_hi_nz;
    assign wr_over    = bus.ioctl_wr & bus.ioctl_download & addr_hi_nz;
    assign grow       = wr_ok & (|(bus.ioctl_addr[CART_ADDR_W-1:0] & ~bus.cart_mask));

    // Timer reloads coincide with the state transition so each phase starts on the same edge.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state == ST_LOAD && dl_fall && bus.skip_logo) begin
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
        end else if (state == ST_SETTLE && !dl_rise && tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = PULSE_LD;
        end
    end

    assign tmr_en = (state == ST_SETTLE || state == ST_PULSE) && !dl_rise && !tmr_load;

    cart_skip_timer #(.W(TIMER_W)) u_timer (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= ST_IDLE;
            dl_q           <= 1'b0;
            bus.cart_wr    <= 1'b0;
            bus.cart_addr  <= '0;
            bus.cart_data  <= '0;
            bus.cart_mask  <= '0;
            bus.oversize   <= 1'b0;
            bus.load_reset <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            dl_q        <= bus.ioctl_download;
            bus.cart_wr <= wr_ok;
            if (wr_ok) begin
                bus.cart_addr <= bus.ioctl_addr[CART_ADDR_W-1:0];
                bus.cart_data <= bus.ioctl_dout;
            end

            // A new download start wins over any write landing in the same cycle.
            if (dl_rise) begin
                bus.cart_mask <= '0;
                bus.oversize  <= 1'b0;
            end else begin
                if (grow)    bus.cart_mask <= mask_grow(bus.cart_mask);
                if (wr_over) bus.oversize  <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (dl_rise) begin
                        state          <= ST_LOAD;
                        bus.load_reset <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (dl_fall) begin
                        state          <= bus.skip_logo ? ST_SETTLE : ST_IDLE;
                        bus.load_reset <= 1'b0;
                        bus.busy       <= bus.skip_logo;
                    end
                end
                ST_SETTLE: begin
                    if (dl_rise) begin
                        state          <= ST_LOAD;
                        bus.load_reset <= 1'b1;
                    end else if (tmr_zero) begin
                        state          <= ST_PULSE;
                        bus.load_reset <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (dl_rise) begin
                        state <= ST_LOAD;
                    end else if (tmr_zero) begin
                        state          <= ST_IDLE;
                        bus.load_reset <= 1'b0;
                        bus.busy       <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    bus.load_reset <= 1'b0;
                    bus.busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Directed and randomized bench for cart_load_ctrl with a list-based model of downloads.
module tb_cart_load_ctrl;
    import vectrex_pkg::*;

    localparam int SKIP = 100;
    localparam int PLEN = 10;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [24:0] stim_addr[$];
    logic [7:0]  stim_data[$];
    logic [14:0] obs_addr[$];
    logic [7:0]  obs_data[$];

    cart_load_ctrl_if bus ();

    cart_load_ctrl #(.SKIP_DELAY(SKIP), .PULSE_LEN(PLEN)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #3000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled, outputs observed 1 time unit later.
    task automatic step();
        @(posedge clk_sys);
        #1;
        if (bus.cart_wr === 1'b1) begin
            obs_addr.push_back(bus.cart_addr);
            obs_data.push_back(bus.cart_data);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr"},   32'(bus.cart_wr),    32'd0);
        chk({tag, "_addr"}, 32'(bus.cart_addr),  32'd0);
        chk({tag, "_data"}, 32'(bus.cart_data),  32'd0);
        chk({tag, "_mask"}, 32'(bus.cart_mask),  32'd0);
        chk({tag, "_ovs"},  32'(bus.oversize),   32'd0);
        chk({tag, "_lr"},   32'(bus.load_reset), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy),       32'd0);
    endtask

    // Plays stim_* as one download and checks the write stream, mask and oversize against the list.
    task automatic run_download(input bit skip, input int gap_max, input string tag);
        logic [14:0] m;
        bit          ov;
        bit          lr_ok;
        int          k;
        int          mism;
        obs_addr.delete();
        obs_data.delete();
        bus.skip_logo      = skip;
        bus.ioctl_download = 1'b1;
        step();
        chk({tag, "_rise_lr"},   32'(bus.load_reset), 32'd1);
        chk({tag, "_rise_busy"}, 32'(bus.busy),       32'd1);
        chk({tag, "_rise_mask"}, 32'(bus.cart_mask),  32'd0);
        chk({tag, "_rise_ovs"},  32'(bus.oversize),   32'd0);
        lr_ok = 1'b1;
        foreach (stim_addr[i]) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = stim_addr[i];
            bus.ioctl_dout = stim_data[i];
            step();
            bus.ioctl_wr = 1'b0;
            if (bus.load_reset !== 1'b1) lr_ok = 1'b0;
            repeat ($urandom_range(gap_max, 0)) begin
                step();
                if (bus.load_reset !== 1'b1) lr_ok = 1'b0;
            end
        end
        chk({tag, "_lr_held"}, 32'(lr_ok), 32'd1);

        m = '0; ov = 1'b0; k = 0; mism = 0;
        foreach (stim_addr[i]) begin
            if (stim_addr[i] >= 25'h8000) begin
                ov = 1'b1;
            end else begin
                if (k >= obs_addr.size() || obs_addr[k] != stim_addr[i][14:0] || obs_data[k] != stim_data[i])
                    mism++;
                k++;
                if ((stim_addr[i][14:0] & ~m) != 15'd0) m = (m << 1) | 15'd1;
            end
        end
        chk({tag, "_nwr"},    32'(obs_addr.size()), 32'(k));
        chk({tag, "_stream"}, 32'(mism),            32'd0);
        chk({tag, "_mask"},   32'(bus.cart_mask),   32'(m));
        chk({tag, "_ovs"},    32'(bus.oversize),    32'(ov));

        bus.ioctl_download = 1'b0;
        step();
        chk({tag, "_fall_lr"},   32'(bus.load_reset), 32'd0);
        chk({tag, "_fall_busy"}, 32'(bus.busy),       32'(skip));
    endtask

    // Call right after run_download with skip=1: measures the low gap and the pulse.
    task automatic measure_skip(input string tag);
        int lo;
        int hi;
        lo = 1;
        while (bus.load_reset !== 1'b1 && lo < 1000) begin
            step();
            if (bus.load_reset !== 1'b1) lo++;
        end
        hi = 0;
        while (bus.load_reset === 1'b1 && hi < 1000) begin
            hi++;
            step();
        end
        chk({tag, "_low_cycles"},  32'(lo),         32'(SKIP - PLEN));
        chk({tag, "_high_cycles"}, 32'(hi),         32'(PLEN));
        chk({tag, "_end_busy"},    32'(bus.busy),   32'd0);
    endtask

    initial begin
        int  n;
        int  g;
        bit  sk;
        bit  seen_hi;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.skip_logo      = 1'b0;

        step();
        step();
        chk_reset_vals("por");
        reset = 1'b0;
        step();

        // 8 KiB image, no skip, then with skip.
        stim_addr.delete(); stim_data.delete();
        for (int i = 0; i < 8192; i++) begin
            stim_addr.push_back(25'(i));
            stim_data.push_back(8'($urandom));
        end
        run_download(1'b0, 0, "img8k");
        chk("img8k_mask_abs", 32'(bus.cart_mask), 32'h1FFF);
        chk("img8k_nwr_abs",  32'(obs_addr.size()), 32'd8192);
        run_download(1'b1, 0, "img8k_skip");
        measure_skip("img8k_skip");

        // Oversize write: flagged, not forwarded, mask untouched.
        stim_addr = '{25'h0, 25'h1, 25'h8000, 25'h2};
        stim_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_download(1'b0, 1, "ovs");
        chk("ovs_flag",  32'(bus.oversize),    32'd1);
        chk("ovs_nwr",   32'(obs_addr.size()), 32'd3);
        chk("ovs_mask",  32'(bus.cart_mask),   32'h3);

        // New download during the settle wait aborts the pending pulse.
        stim_addr = '{25'h5, 25'h6};
        stim_data = '{8'hA5, 8'h5A};
        run_download(1'b1, 0, "abort");
        repeat (20) step();
        bus.ioctl_download = 1'b1;
        step();
        chk("abort_lr",   32'(bus.load_reset), 32'd1);
        chk("abort_busy", 32'(bus.busy),       32'd1);
        chk("abort_mask", 32'(bus.cart_mask),  32'd0);
        chk("abort_ovs_cleared", 32'(bus.oversize), 32'd0);
        bus.skip_logo      = 1'b0;
        bus.ioctl_download = 1'b0;
        step();
        chk("abort_end_busy", 32'(bus.busy), 32'd0);
        seen_hi = 1'b0;
        repeat (150) begin
            step();
            if (bus.load_reset !== 1'b0) seen_hi = 1'b1;
        end
        chk("abort_no_pulse", 32'(seen_hi), 32'd0);

        // Reset while the second reset pulse is active.
        stim_addr = '{25'h0, 25'h1};
        stim_data = '{8'h01, 8'h02};
        run_download(1'b1, 0, "rst_pulse");
        g = 0;
        while (bus.load_reset !== 1'b1 && g < 1000) begin
            step();
            g++;
        end
        chk("rst_pulse_reached", 32'(bus.load_reset), 32'd1);
        step();
        reset = 1'b1;
        step();
        chk_reset_vals("rst_pulse");
        reset = 1'b0;
        seen_hi = 1'b0;
        repeat (20) begin
            step();
            if (bus.load_reset !== 1'b0 || bus.busy !== 1'b0) seen_hi = 1'b1;
        end
        chk("rst_pulse_quiet", 32'(seen_hi), 32'd0);

        // Reset in the middle of a download.
        bus.skip_logo      = 1'b0;
        bus.ioctl_download = 1'b1;
        step();
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h7;
        bus.ioctl_dout = 8'hC3;
        step();
        bus.ioctl_wr = 1'b0;
        chk("rst_load_wr_before", 32'(bus.cart_wr), 32'd1);
        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        step();
        chk_reset_vals("rst_load");
        reset = 1'b0;
        step();
        chk("rst_load_after_busy", 32'(bus.busy), 32'd0);

        // Fill the mask to 15 bits, then start a download with a write in the same cycle.
        stim_addr.delete(); stim_data.delete();
        for (int b = 0; b < 15; b++) begin
            stim_addr.push_back(25'(1) << b);
            stim_data.push_back(8'(b));
        end
        run_download(1'b0, 0, "m15");
        chk("m15_mask_abs", 32'(bus.cart_mask), 32'h7FFF);
        bus.ioctl_download = 1'b1;
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_addr     = 25'h3;
        bus.ioctl_dout     = 8'h5A;
        step();
        bus.ioctl_wr = 1'b0;
        chk("coin_mask", 32'(bus.cart_mask),  32'd0);
        chk("coin_wr",   32'(bus.cart_wr),    32'd1);
        chk("coin_addr", 32'(bus.cart_addr),  32'h3);
        chk("coin_data", 32'(bus.cart_data),  32'h5A);
        chk("coin_lr",   32'(bus.load_reset), 32'd1);
        step();
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_addr     = 25'h5;
        step();
        bus.ioctl_wr = 1'b0;
        chk("fallwr_wr",   32'(bus.cart_wr),   32'd0);
        chk("fallwr_addr", 32'(bus.cart_addr), 32'h3);
        chk("fallwr_mask", 32'(bus.cart_mask), 32'd0);

        // Write strobe with no download in progress.
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h1FF;
        step();
        bus.ioctl_wr = 1'b0;
        chk("idle_wr",   32'(bus.cart_wr),   32'd0);
        chk("idle_mask", 32'(bus.cart_mask), 32'd0);
        chk("idle_busy", 32'(bus.busy),      32'd0);

        // Randomized downloads.
        for (int r = 0; r < 8; r++) begin
            stim_addr.delete(); stim_data.delete();
            n = $urandom_range(40, 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(7, 0) == 0)
                    stim_addr.push_back(25'($urandom_range(32'h1FFFFFF, 32'h8000)));
                else
                    stim_addr.push_back(25'($urandom_range(32'h7FFF, 0)));
                stim_data.push_back(8'($urandom));
            end
            sk = 1'($urandom_range(1, 0));
            run_download(sk, 2, "rnd");
            if (sk) measure_skip("rnd");
            repeat ($urandom_range(3, 0)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
